// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - main sequencing FSM for the multicycle MIPS datapath
//
// Steps each instruction through FETCH/DECODE/execute/memory/writeback and
// drives every datapath mux select and write enable.
//
// Ports:
//   clk       rising-edge clock
//   reset     synchronous, active-high reset
//   Opcode    IR[31:26], meaningful from DECODE onward
//   Zero      ALU zero flag, used in BRANCH
//   MemReady  memory access completes this cycle
//   IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
//   ALUSrcB, ALUOp, PCSrc, PCEn   datapath controls
//   State     current state code, for debug visibility
module multicycle_control_unit #(
  parameter logic [5:0] OP_RTYPE = 6'h00,
  parameter logic [5:0] OP_LW    = 6'h23,
  parameter logic [5:0] OP_SW    = 6'h2B,
  parameter logic [5:0] OP_BEQ   = 6'h04,
  parameter logic [5:0] OP_BNE   = 6'h05,
  parameter logic [5:0] OP_ADDI  = 6'h08,
  parameter logic [5:0] OP_J     = 6'h02
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Opcode,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSrc,
  output logic       PCEn,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  state_t state;
  state_t next_state;
  state_t cur;

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= next_state;
  end

  always_comb begin
    next_state = S_FETCH;
    case (state)
      S_FETCH:   next_state = MemReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (Opcode)
          OP_LW, OP_SW:   next_state = S_MEMADR;
          OP_RTYPE:       next_state = S_EXECUTE;
          OP_BEQ, OP_BNE: next_state = S_BRANCH;
          OP_ADDI:        next_state = S_ADDIEX;
          OP_J:           next_state = S_JUMP;
          default:        next_state = S_FETCH;
        endcase
      end
      S_MEMADR:  next_state = (Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   next_state = MemReady ? S_MEMWB : S_MEMRD;
      S_MEMWR:   next_state = MemReady ? S_FETCH : S_MEMWR;
      S_EXECUTE: next_state = S_ALUWB;
      S_ADDIEX:  next_state = S_ADDIWB;
      default:   next_state = S_FETCH;
    endcase
  end

  // While reset is high the outputs decode as FETCH so the datapath sees
  // a benign configuration, and the write enables are masked below.
  always_comb begin
    cur      = reset ? S_FETCH : state;
    IorD     = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    ALUOp    = 2'b00;
    PCSrc    = 2'b00;
    PCEn     = 1'b0;
    case (cur)
      S_FETCH: begin
        ALUSrcB = 2'b01;
        IRWrite = MemReady;
        PCEn    = MemReady;
      end
      // Precompute PC+4 + (SignImm<<2) so BRANCH can take it from ALUOut.
      S_DECODE:  ALUSrcB = 2'b11;
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD:   IorD = 1'b1;
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECUTE: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      S_ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b01;
        PCSrc   = 2'b01;
        PCEn    = (Opcode == OP_BNE) ? ~Zero : Zero;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_ADDIWB:  RegWrite = 1'b1;
      S_JUMP: begin
        PCSrc = 2'b10;
        PCEn  = 1'b1;
      end
      default: ;
    endcase
    if (reset) begin
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      PCEn     = 1'b0;
    end
  end

  assign State = state;

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Main sequencing FSM for the multicycle MIPS datapath.
- Steps the datapath through FETCH/DECODE/execute/memory/writeback each instruction and drives every mux select and write enable.
- Drives PC-update control, including the branch-target path (PC+4 plus shifted immediate, PCSrc=01).
- Sits between the instruction register opcode field, the ALU Zero flag and the memory ready line, and the datapath enables.

Parameters:
OP_RTYPE, 6'h00, R-type opcode
OP_LW, 6'h23, load word opcode
OP_SW, 6'h2B, store word opcode
OP_BEQ, 6'h04, branch-equal opcode
OP_BNE, 6'h05, branch-not-equal opcode
OP_ADDI, 6'h08, add-immediate opcode
OP_J, 6'h02, jump opcode

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
Opcode  input  6  IR[31:26], valid from DECODE onward
Zero  input  1  ALU zero flag, sampled in BRANCH
MemReady  input  1  memory access completes this cycle
IorD  output  1  0=PC, 1=ALUOut as memory address
MemWrite  output  1  memory write strobe
IRWrite  output  1  instruction register load
RegDst  output  1  0=rt, 1=rd write register
MemtoReg  output  1  0=ALUOut, 1=MDR write data
RegWrite  output  1  register file write
ALUSrcA  output  1  0=PC, 1=A
ALUSrcB  output  2  00=B, 01=4, 10=SignImm, 11=SignImm<<2
ALUOp  output  2  00=add, 01=sub, 10=funct, 11=reserved
PCSrc  output  2  00=ALUResult, 01=ALUOut (branch target), 10=jump address
PCEn  output  1  PC register enable
State  output  4  current state, debug/verification visibility

Behaviour:
- Interface: one clock, clk. reset is synchronous and active-high.
- Reset:
  - While reset=1 at a rising edge, State <= FETCH.
  - While reset is high, MemWrite, IRWrite, RegWrite and PCEn are forced to 0 combinationally.
  - All other outputs take their FETCH values.
- State encoding:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7.
  - BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11.
  - Codes 12-15 are illegal and go to FETCH next cycle with all write enables 0.
- Outputs are decoded from State, plus the MemReady/Zero terms below. Any output not listed for a state is 0.
- FETCH:
  - IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00.
  - IRWrite=MemReady; PCEn=MemReady.
  - Stays in FETCH while MemReady=0; goes to DECODE when MemReady=1.
- DECODE:
  - ALUSrcA=0, ALUSrcB=11, ALUOp=00 (precomputes the branch target into ALUOut).
  - Next state by Opcode: LW/SW->MEMADR, RTYPE->EXECUTE, BEQ/BNE->BRANCH, ADDI->ADDIEX, J->JUMP.
  - Any other opcode -> FETCH, with no register or memory side effects.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next is MEMRD if Opcode=LW, else MEMWR.
- MEMRD: IorD=1. Holds until MemReady=1, then MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1. Next FETCH.
- MEMWR: IorD=1, MemWrite=1. Holds until MemReady=1, then FETCH. MemWrite stays asserted through the stall.
- EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next ALUWB.
- ALUWB: RegDst=1, MemtoReg=0, RegWrite=1. Next FETCH.
- BRANCH:
  - ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01.
  - PCEn = Zero for BEQ; PCEn = ~Zero for BNE.
  - Next FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next ADDIWB.
- ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1. Next FETCH.
- JUMP: PCSrc=10, PCEn=1. Next FETCH.
- Latency in cycles, with no stalls:
  - LW=5, SW=4, RTYPE=4, ADDI=4, BEQ/BNE=3, J=3, unknown opcode=2.
  - Each MemReady=0 cycle adds 1 cycle in FETCH, MEMRD or MEMWR.
- Opcode is ignored in FETCH. It must stay stable from DECODE to the end of the instruction; IRWrite=0 outside FETCH guarantees this.
- Reset mid-instruction: the next edge enters FETCH. No RegWrite, MemWrite or PCEn pulse is emitted on the reset cycle.

Test Plan:
- Reset 2 cycles, then MemReady=1, Opcode=6'h23 -> State 0,1,2,3,4,0. RegWrite=1 and MemtoReg=1 only in state 4; PCEn=1 only in state 0.
- Opcode=6'h00 with MemReady=1 -> State 0,1,6,7,0. ALUOp=10 in state 6; RegDst=1, RegWrite=1 in state 7.
- Opcode=6'h04 with Zero=1 -> PCEn=1, PCSrc=01 in state 8. Repeat with Zero=0 -> PCEn=0. Opcode=6'h05 with Zero=0 -> PCEn=1.
- Opcode=6'h2B with MemReady low for 3 cycles in MEMWR -> State held at 5 for 4 cycles, MemWrite=1 throughout, then FETCH.
- Opcode=6'h3F (unknown) -> State 0,1,0. RegWrite, MemWrite and PCEn stay 0 in DECODE.
- Assert reset while in MEMRD (State=3) -> IRWrite, RegWrite, MemWrite and PCEn are 0 during reset, and State=0 after the edge. Opcode=6'h02 afterwards -> State 0,1,11,0 with PCSrc=10 and PCEn=1 in state 11.
